// File: rtl/ex_muldiv_stage_pkg.sv
// Shared op codes, FSM encodings and bus widths for the THCO-MIPS execute stage.
// Build option: define EX_DIV_EN to include the DIV/MOD datapath.
package ex_muldiv_stage_pkg;

    localparam int EX_DATA_W     = 16;
    localparam int EX_ITER       = 16;
    localparam int EX_CNT_W      = 5;
    localparam int ALUOP_W       = 5;
    localparam int STALL_W       = 6;
    localparam int REG_ADDR_W    = 4;
    localparam int STALL_EX_BIT  = 3;
    localparam int STALL_MEM_BIT = 4;

    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b0;

    localparam logic [REG_ADDR_W-1:0] DISABLE_REG_ADDR = '0;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_NOP  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_NOT  = 5'd6,
        ALU_SLL  = 5'd7,
        ALU_SRL  = 5'd8,
        ALU_SRA  = 5'd9,
        ALU_SLT  = 5'd10,
        ALU_SLTU = 5'd11,
        ALU_CMP  = 5'd12,
        ALU_MOV  = 5'd13,
        ALU_MUL  = 5'd14,
        ALU_DIV  = 5'd15,
        ALU_MOD  = 5'd16
    } alu_op_e;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_BUSY = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

    // Ops that go through the iterative unit rather than the single-cycle ALU.
    function automatic logic is_muldiv_op(input logic [ALUOP_W-1:0] op);
`ifdef EX_DIV_EN
        return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
`else
        return (op == ALU_MUL);
`endif
    endfunction

endpackage

// File: rtl/ex_muldiv_stage_muldiv.sv
// Iterative shift-add multiplier and restoring divider with an IDLE/BUSY/DONE FSM.
// Build option: EX_DIV_EN adds the DIV/MOD datapath; otherwise only MUL is handled.
module ex_muldiv_stage_muldiv
    import ex_muldiv_stage_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int ITER   = EX_ITER,
    parameter int CNT_W  = EX_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ALUOP_W-1:0] op_i,
    input  logic [DATA_W-1:0]  op1_i,
    input  logic [DATA_W-1:0]  op2_i,
    input  logic               stall_ex_i,
    output logic [DATA_W-1:0]  result_o,
    output logic               busy_o,
    output ex_state_e          state_o
);

    ex_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic               launch;

`ifdef EX_DIV_EN
    logic [ALUOP_W-1:0] op_q, op_d;
    logic [DATA_W:0]    rem_shift;
    logic [DATA_W:0]    rem_diff;
`endif

    assign launch   = start_i && is_muldiv_op(op_i);
    assign busy_o   = ((state_q == EX_IDLE) && launch) || (state_q == EX_BUSY);
    assign state_o  = state_q;

    // MUL: acc = product, a = multiplicand, b = multiplier.
    // DIV/MOD: acc = remainder, a = dividend shifting into quotient, b = divisor.
`ifdef EX_DIV_EN
    assign result_o = (op_q == ALU_DIV) ? a_q : acc_q;
`else
    assign result_o = acc_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef EX_DIV_EN
        op_d      = op_q;
        rem_shift = {acc_q, a_q[DATA_W-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
`endif
        case (state_q)
            EX_IDLE: begin
                if (launch) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    a_d     = op1_i;
                    b_d     = op2_i;
                    state_d = EX_BUSY;
`ifdef EX_DIV_EN
                    op_d = op_i;
                    if ((op_i != ALU_MUL) && (op2_i == '0)) begin
                        acc_d   = op1_i;
                        a_d     = '1;
                        state_d = EX_DONE;
                    end
`endif
                end
            end
            EX_BUSY: begin
                cnt_d = cnt_q + 1'b1;
`ifdef EX_DIV_EN
                if (op_q == ALU_MUL) begin
`endif
                    if (b_q[0]) begin
                        acc_d = acc_q + a_q;
                    end
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
`ifdef EX_DIV_EN
                end else begin
                    if (rem_shift >= {1'b0, b_q}) begin
                        acc_d = rem_diff[DATA_W-1:0];
                        a_d   = {a_q[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_d = rem_shift[DATA_W-1:0];
                        a_d   = {a_q[DATA_W-2:0], 1'b0};
                    end
                end
`endif
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = EX_DONE;
                end
            end
            EX_DONE: begin
                if (stall_ex_i == NO_STOP) begin
                    state_d = EX_IDLE;
                end
            end
            default: state_d = EX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= EX_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef EX_DIV_EN
            op_q    <= ALU_NOP;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef EX_DIV_EN
            op_q    <= op_d;
`endif
        end
    end

endmodule

// File: rtl/ex_muldiv_stage.sv
// THCO-MIPS execute stage: single-cycle ALU plus iterative MUL (and DIV/MOD with EX_DIV_EN).
// Build option: EX_DIV_EN enables DIV/MOD; otherwise they are treated as unknown ops.
module ex_muldiv_stage
    import ex_muldiv_stage_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int ITER   = EX_ITER,
    parameter int CNT_W  = EX_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic [ALUOP_W-1:0]    aluOp_i,
    input  logic [DATA_W-1:0]     operand1_i,
    input  logic [DATA_W-1:0]     operand2_i,
    input  logic                  wReg_i,
    input  logic [REG_ADDR_W-1:0] wRegAddr_i,
    output logic                  wReg_o,
    output logic [REG_ADDR_W-1:0] wRegAddr_o,
    output logic [DATA_W-1:0]     wData_o,
    output logic                  stallReq_o
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  alu_data;
    logic               alu_valid;
    logic               md_op;
    logic [DATA_W-1:0]  md_result;
    logic               md_busy;
    ex_state_e          md_state;
    logic               unused_stall;

    // Only the EX bit of the stall vector matters here.
    assign unused_stall = ^{stall[STALL_W-1:STALL_EX_BIT+1], stall[STALL_EX_BIT-1:0]};
    assign shamt        = operand2_i[SHAMT_W-1:0];
    assign md_op        = is_muldiv_op(aluOp_i);

    ex_muldiv_stage_muldiv #(
        .DATA_W (DATA_W),
        .ITER   (ITER),
        .CNT_W  (CNT_W)
    ) u_muldiv (
        .clk        (clk),
        .rst        (rst),
        .start_i    (md_op),
        .op_i       (aluOp_i),
        .op1_i      (operand1_i),
        .op2_i      (operand2_i),
        .stall_ex_i (stall[STALL_EX_BIT]),
        .result_o   (md_result),
        .busy_o     (md_busy),
        .state_o    (md_state)
    );

    always_comb begin
        alu_data  = '0;
        alu_valid = 1'b1;
        case (aluOp_i)
            ALU_NOP:  alu_data = '0;
            ALU_ADD:  alu_data = operand1_i + operand2_i;
            ALU_SUB:  alu_data = operand1_i - operand2_i;
            ALU_AND:  alu_data = operand1_i & operand2_i;
            ALU_OR:   alu_data = operand1_i | operand2_i;
            ALU_XOR:  alu_data = operand1_i ^ operand2_i;
            ALU_NOT:  alu_data = ~operand1_i;
            ALU_SLL:  alu_data = operand1_i << shamt;
            ALU_SRL:  alu_data = operand1_i >> shamt;
            ALU_SRA:  alu_data = $unsigned($signed(operand1_i) >>> shamt);
            ALU_SLT:  alu_data[0] = $signed(operand1_i) < $signed(operand2_i);
            ALU_SLTU: alu_data[0] = operand1_i < operand2_i;
            ALU_CMP:  alu_data[0] = operand1_i != operand2_i;
            ALU_MOV:  alu_data = operand2_i;
            default:  alu_valid = 1'b0;
        endcase
    end

    // A finished result wins over the op input so it stays visible under back-pressure.
    always_comb begin
        wReg_o     = WRITE_DISABLE;
        wRegAddr_o = DISABLE_REG_ADDR;
        wData_o    = '0;
        stallReq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            wRegAddr_o = wRegAddr_i;
            if (md_state == EX_DONE) begin
                wData_o = md_result;
                wReg_o  = wReg_i;
            end else if (md_op) begin
                wReg_o     = wReg_i;
                stallReq_o = md_busy;
            end else begin
                wData_o = alu_data;
                wReg_o  = wReg_i & alu_valid;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Self-checking bench for ex_muldiv_stage: ALU vector table, scoreboarded MUL/DIV/MOD sequences.
module tb_ex_muldiv_stage;
    import ex_muldiv_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  alu_op;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        wreg_i;
    logic [3:0]  waddr_i;
    logic        wreg_o;
    logic [3:0]  waddr_o;
    logic [15:0] wdata_o;
    logic        stall_req;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_data;
        logic        exp_wreg;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ex_muldiv_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .aluOp_i    (alu_op),
        .operand1_i (op1),
        .operand2_i (op2),
        .wReg_i     (wreg_i),
        .wRegAddr_i (waddr_i),
        .wReg_o     (wreg_o),
        .wRegAddr_o (waddr_o),
        .wData_o    (wdata_o),
        .stallReq_o (stall_req)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [15:0] act);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, {16'h0, act}, {16'h0, e});
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic wr, input logic [3:0] addr);
        alu_op  = op;
        op1     = a;
        op2     = b;
        wreg_i  = wr;
        waddr_i = addr;
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] e, input logic ew);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_data = e; v.exp_wreg = ew;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] cur_state();
        return {30'h0, dut.u_muldiv.state_o};
    endfunction

    task automatic apply_comb(input vec_t v);
        logic [3:0] addr;
        addr = 4'($urandom_range(1, 15));
        @(negedge clk);
        drive(v.op, v.a, v.b, 1'b1, addr);
        exp_q.push_back(v.exp_data);
        #1;
        pop_check("alu_wdata", wdata_o);
        check("alu_wreg", {31'h0, wreg_o}, {31'h0, v.exp_wreg});
        check("alu_waddr", {28'h0, waddr_o}, {28'h0, addr});
        check("alu_stallreq", {31'h0, stall_req}, 32'd0);
    endtask

    // Starts a multi-cycle op in the IDLE cycle and returns positioned in its DONE cycle.
    task automatic run_md(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] e, input int exp_stalls);
        logic [3:0] addr;
        int         stalls;
        int         pass_err;
        int         guard;
        addr = 4'($urandom_range(1, 15));
        @(negedge clk);
        check("md_idle_before", cur_state(), {30'h0, EX_IDLE});
        drive(op, a, b, 1'b1, addr);
        exp_q.push_back(e);
        #1;
        stalls   = 0;
        pass_err = 0;
        guard    = 0;
        while (stall_req === 1'b1 && guard < 40) begin
            stalls++;
            if (wreg_o !== 1'b1 || waddr_o !== addr) pass_err++;
            @(negedge clk);
            #1;
            guard++;
        end
        check("md_stall_cycles", stalls, exp_stalls);
        check("md_state_done", cur_state(), {30'h0, EX_DONE});
        check("md_passthrough_busy", pass_err, 0);
        check("md_wreg_done", {31'h0, wreg_o}, 32'd1);
        check("md_waddr_done", {28'h0, waddr_o}, {28'h0, addr});
        pop_check("md_wdata", wdata_o);
    endtask

    // Lets the pipeline advance out of DONE.
    task automatic finish_md();
        stall = 6'b0;
        drive(ALU_NOP, 16'h0, 16'h0, 1'b0, 4'h0);
    endtask

    function automatic logic [15:0] model(input logic [4:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [16:0] s;
        case (op)
            ALU_ADD: begin s = {1'b0, a} + {1'b0, b}; return s[15:0]; end
            ALU_SUB: begin s = {1'b0, a} + {1'b0, ~b} + 17'd1; return s[15:0]; end
            ALU_XOR: return a ^ b;
            ALU_SLTU: return (a < b) ? 16'd1 : 16'd0;
            ALU_SLT: begin
                if (a[15] != b[15]) return a[15] ? 16'd1 : 16'd0;
                return (a < b) ? 16'd1 : 16'd0;
            end
            default: return 16'h0;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  rops[5];
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] prod;
        logic [4:0]  rop;
        vec_t        rv;
        logic [15:0] held;

        add_vec(ALU_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b1);
        add_vec(ALU_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b1);
        add_vec(ALU_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b1);
        add_vec(ALU_OR,   16'hF0F0, 16'h0F01, 16'hFFF1, 1'b1);
        add_vec(ALU_XOR,  16'hAAAA, 16'hFFFF, 16'h5555, 1'b1);
        add_vec(ALU_NOT,  16'h1234, 16'h0000, 16'hEDCB, 1'b1);
        add_vec(ALU_SLL,  16'h0001, 16'h0013, 16'h0008, 1'b1);
        add_vec(ALU_SRL,  16'h8000, 16'h0004, 16'h0800, 1'b1);
        add_vec(ALU_SRA,  16'h8000, 16'h0004, 16'hF800, 1'b1);
        add_vec(ALU_SLT,  16'h8000, 16'h0001, 16'h0001, 1'b1);
        add_vec(ALU_SLTU, 16'h8000, 16'h0001, 16'h0000, 1'b1);
        add_vec(ALU_CMP,  16'h0005, 16'h0005, 16'h0000, 1'b1);
        add_vec(ALU_CMP,  16'h0005, 16'h0006, 16'h0001, 1'b1);
        add_vec(ALU_MOV,  16'h1111, 16'hBEEF, 16'hBEEF, 1'b1);
        add_vec(ALU_NOP,  16'h1234, 16'h5678, 16'h0000, 1'b1);
        add_vec(5'h1F,    16'h1234, 16'h5678, 16'h0000, 1'b0);
`ifndef EX_DIV_EN
        add_vec(ALU_DIV,  16'd1000, 16'd7, 16'h0000, 1'b0);
        add_vec(ALU_MOD,  16'd1000, 16'd7, 16'h0000, 1'b0);
`endif

        // Reset: outputs forced off even with a live MUL on the inputs.
        rst   = 1'b0;
        stall = 6'b0;
        drive(ALU_MUL, 16'h0003, 16'h0004, 1'b1, 4'h5);
        @(negedge clk);
        #1;
        check("rst_wdata", {16'h0, wdata_o}, 32'h0);
        check("rst_wreg", {31'h0, wreg_o}, 32'h0);
        check("rst_waddr", {28'h0, waddr_o}, 32'h0);
        check("rst_stallreq", {31'h0, stall_req}, 32'h0);
        @(negedge clk);
        check("rst_state", cur_state(), {30'h0, EX_IDLE});
        drive(ALU_NOP, 16'h0, 16'h0, 1'b0, 4'h0);
        rst = 1'b1;

        foreach (vecs[i]) apply_comb(vecs[i]);

        rops[0] = ALU_ADD; rops[1] = ALU_SUB; rops[2] = ALU_XOR;
        rops[3] = ALU_SLT; rops[4] = ALU_SLTU;
        for (int i = 0; i < 20; i++) begin
            rop = rops[$urandom_range(0, 4)];
            ra  = 16'($urandom_range(0, 16'hFFFF));
            rb  = 16'($urandom_range(0, 16'hFFFF));
            rv.op = rop; rv.a = ra; rv.b = rb; rv.exp_data = model(rop, ra, rb); rv.exp_wreg = 1'b1;
            apply_comb(rv);
        end

        // MUL, then back-to-back random MULs starting in the IDLE cycle after DONE.
        run_md(ALU_MUL, 16'h0123, 16'h0010, 16'h1230, 17);
        finish_md();
        for (int i = 0; i < 4; i++) begin
            ra   = 16'($urandom_range(0, 16'hFFFF));
            rb   = 16'($urandom_range(0, 16'hFFFF));
            prod = {16'h0, ra} * {16'h0, rb};
            run_md(ALU_MUL, ra, rb, prod[15:0], 17);
            finish_md();
        end
        run_md(ALU_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 17);
        finish_md();

`ifdef EX_DIV_EN
        run_md(ALU_DIV, 16'd1000, 16'd7, 16'd142, 17);
        finish_md();
        run_md(ALU_MOD, 16'd1000, 16'd7, 16'd6, 17);
        finish_md();
        run_md(ALU_DIV, 16'h1234, 16'h0000, 16'hFFFF, 1);
        finish_md();
        run_md(ALU_MOD, 16'h1234, 16'h0000, 16'h1234, 1);
        finish_md();
        run_md(ALU_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 17);
        finish_md();
`endif

        // Back-pressure: DONE held for 3 cycles with the result stable.
        run_md(ALU_MUL, 16'h0123, 16'h0010, 16'h1230, 17);
        held  = 16'h1230;
        stall = 6'b001000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp_state_done", cur_state(), {30'h0, EX_DONE});
            check("bp_wdata_held", {16'h0, wdata_o}, {16'h0, held});
            check("bp_stallreq", {31'h0, stall_req}, 32'h0);
        end
        finish_md();
        @(negedge clk);
        #1;
        check("bp_release_idle", cur_state(), {30'h0, EX_IDLE});

        // Reset in the 8th BUSY cycle abandons the MUL.
        @(negedge clk);
        drive(ALU_MUL, 16'h00FF, 16'h0101, 1'b1, 4'h9);
        #1;
        check("rstmid_start_stall", {31'h0, stall_req}, 32'd1);
        repeat (8) @(negedge clk);
        check("rstmid_busy", cur_state(), {30'h0, EX_BUSY});
        rst = 1'b0;
        drive(ALU_NOP, 16'h0, 16'h0, 1'b0, 4'h0);
        #1;
        check("rstmid_stallreq_low", {31'h0, stall_req}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_state_idle", cur_state(), {30'h0, EX_IDLE});
        check("rstmid_stallreq", {31'h0, stall_req}, 32'h0);
        check("rstmid_wdata", {16'h0, wdata_o}, 32'h0);
        rv.op = ALU_ADD; rv.a = 16'h0003; rv.b = 16'h0004; rv.exp_data = 16'h0007; rv.exp_wreg = 1'b1;
        apply_comb(rv);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
